// File: rtl/inst_rom_arbiter.sv
// Shares the instruction ROM between IF (fixed priority) and DBG (starvation-guarded); grant is combinational, read data lands 1 cycle after grant.
// Backpressure: a denied requester holds req/addr until gnt; optional perf counters under ROM_ARB_PERF_EN.
module inst_rom_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   output logic        dbg_gnt,
   output logic [31:0] dbg_rdata,
   output logic        dbg_valid,
   output logic        rom_ce,
   output logic [31:0] rom_addr,
`ifdef ROM_ARB_PERF_EN
   output logic [31:0] perf_conflicts,
   output logic [31:0] perf_forced,
`endif
   input  logic [31:0] rom_inst
);

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;
   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt;
   logic              dbg_win;

   // Grants are masked by rst so nothing reaches the ROM while in reset.
   assign dbg_win = ~rst & dbg_req & (~if_req | (wait_cnt >= MAX_WAIT_C));
   assign dbg_gnt = dbg_win;
   assign if_gnt  = ~rst & if_req & ~dbg_win;

   always_comb begin
      rom_ce   = CHIP_DISABLE;
      rom_addr = '0;
      if (if_gnt) begin
         rom_ce   = CHIP_ENABLE;
         rom_addr = if_addr;
      end else if (dbg_gnt) begin
         rom_ce   = CHIP_ENABLE;
         rom_addr = dbg_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         dbg_valid <= 1'b0;
         dbg_rdata <= '0;
         wait_cnt  <= '0;
      end else begin
         if_valid  <= if_gnt;
         dbg_valid <= dbg_gnt;
         if (if_gnt)
            if_rdata <= rom_inst;
         if (dbg_gnt)
            dbg_rdata <= rom_inst;
         // Counts consecutive denied cycles of one pending DBG request.
         if (!dbg_req || dbg_gnt)
            wait_cnt <= '0;
         else if (wait_cnt != {WAIT_W{1'b1}})
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

`ifdef ROM_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflicts <= '0;
         perf_forced    <= '0;
      end else begin
         if (if_req && dbg_req)
            perf_conflicts <= perf_conflicts + 32'd1;
         if (dbg_gnt && if_req)
            perf_forced <= perf_forced + 32'd1;
      end
   end
`endif

endmodule
